// File: rtl/quick_spi_pkg.sv
// Shared SPI slave types: FSM state encoding, SPI mode constants and default word width.
package quick_spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_DEFAULT_WIDTH = 8;
  localparam int SPI_CPOL_LOW      = 0;
  localparam int SPI_CPOL_HIGH     = 1;
  localparam int SPI_CPHA_LEAD     = 0;
  localparam int SPI_CPHA_TRAIL    = 1;

endpackage

// File: rtl/quick_spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI line plus a rise/fall detector on the synchronized level.
module quick_spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/quick_spi_slave.sv
// Oversampled SPI slave with a one-word transmit holding register and gapless word streaming.
// Optional macro QUICK_SPI_SLAVE_RX_OVERRUN_EN adds rx_ack / rx_overrun.
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int                    DATA_WIDTH   = SPI_DEFAULT_WIDTH,
  parameter int                    CPOL         = SPI_CPOL_LOW,
  parameter int                    CPHA         = SPI_CPHA_LEAD,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
`ifdef QUICK_SPI_SLAVE_RX_OVERRUN_EN
  ,
  input  logic                  rx_ack,
  output logic                  rx_overrun
`endif
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                  mosi_meta_q, mosi_q;
  spi_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0] rxsh_q, rxsh_d;
  logic [DATA_WIDTH-1:0] txsh_q, txsh_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic                  hold_vld_q, hold_vld_d, fresh_q, fresh_d;
  logic                  take_q, take_d, und_q, und_d;
  logic                  rx_valid_q, rx_valid_d, underrun_q, underrun_d;
  logic [1:0]            settle_q, settle_d;
  logic                  lead_edge, trail_edge, smp_edge, shf_edge;
  logic                  armed, accept, next_avail, enter;
  logic [DATA_WIDTH-1:0] next_word, rx_word;

  quick_spi_sync_edge #(.RST_VAL(CPOL != SPI_CPOL_LOW)) u_sclk_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (sclk),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  quick_spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (ss_n),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  assign lead_edge  = (CPOL == SPI_CPOL_LOW) ? sclk_rise : sclk_fall;
  assign trail_edge = (CPOL == SPI_CPOL_LOW) ? sclk_fall : sclk_rise;
  assign smp_edge   = (CPHA == SPI_CPHA_LEAD) ? lead_edge : trail_edge;
  assign shf_edge   = (CPHA == SPI_CPHA_LEAD) ? trail_edge : lead_edge;

  // The synchronizers come out of reset reading ss_n high; a low line would look
  // like a fresh select, so edges are ignored until the pipeline has refilled.
  assign armed      = (settle_q == 2'd3);
  assign accept     = tx_valid && !hold_vld_q;
  assign next_avail = hold_vld_q || accept;
  assign next_word  = hold_vld_q ? hold_q : (accept ? tx_data : TX_IDLE_WORD);
  assign rx_word    = {rxsh_q, mosi_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rxsh_d     = rxsh_q;
    txsh_d     = txsh_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    fresh_d    = fresh_q;
    take_d     = take_q;
    und_d      = und_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    enter      = 1'b0;
    settle_d   = armed ? settle_q : settle_q + 2'd1;

    if (accept) begin
      hold_d     = tx_data;
      hold_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (armed && ss_fall) begin
          state_d = ST_ACTIVE;
          enter   = 1'b1;
          cnt_d   = '0;
          txsh_d  = next_word;
          fresh_d = 1'b1;
          take_d  = next_avail;
          und_d   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          fresh_d = 1'b0;
          take_d  = 1'b0;
          und_d   = 1'b0;
        end else begin
          // The holding word is only released (and an underrun only reported)
          // once the master actually clocks the first bit of the reloaded word.
          if (smp_edge) begin
            rxsh_d     = rx_word[DATA_WIDTH-2:0];
            take_d     = 1'b0;
            und_d      = 1'b0;
            underrun_d = und_q;
            if (take_q) hold_vld_d = 1'b0;
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
              cnt_d      = '0;
              rx_valid_d = 1'b1;
              rx_data_d  = rx_word;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          if (shf_edge) begin
            fresh_d = 1'b0;
            if (cnt_q != '0) begin
              txsh_d = txsh_q << 1;
            end else if (!fresh_q) begin
              txsh_d = next_word;
              take_d = next_avail;
              und_d  = !next_avail;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rxsh_q      <= '0;
      txsh_q      <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      fresh_q     <= 1'b0;
      take_q      <= 1'b0;
      und_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      settle_q    <= '0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_q      <= mosi_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rxsh_q      <= rxsh_d;
      txsh_q      <= txsh_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      fresh_q     <= fresh_d;
      take_q      <= take_d;
      und_q       <= und_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      settle_q    <= settle_d;
    end
  end

`ifdef QUICK_SPI_SLAVE_RX_OVERRUN_EN
  logic unack_q, rx_overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      unack_q      <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= rx_valid_d && unack_q && !rx_ack;
      if (rx_valid_d)  unack_q <= 1'b1;
      else if (rx_ack) unack_q <= 1'b0;
    end
  end

  assign rx_overrun = rx_overrun_q;
`endif

  // MSB must be on miso in the select cycle itself, before the first leading edge.
  assign miso        = enter ? next_word[DATA_WIDTH-1]
                     : ((state_q == ST_ACTIVE) ? txsh_q[DATA_WIDTH-1] : 1'b0);
  assign miso_oe     = enter || (state_q == ST_ACTIVE);
  assign busy        = (state_q == ST_ACTIVE);
  assign tx_ready    = !hold_vld_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule
